// File: rtl/ba_pkg.sv
// Shared types and helpers for the arbiter grant responder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ba_pkg;

  localparam int NREQ = 4;

  typedef logic [1:0] ba_id_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, GAP} ba_resp_state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic ba_id_t ba_onehot_lsb(input logic [NREQ-1:0] v);
    ba_id_t r;
    r = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) r = ba_id_t'(i);
    end
    return r;
  endfunction

  // True when more than one bit is set.
  function automatic logic ba_is_multihot(input logic [NREQ-1:0] v);
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    return (v & (v - one)) != '0;
  endfunction

endpackage

// File: rtl/ba_tmo_cnt.sv
// Response timeout down-counter: reloads on clr, counts down while en, flags expiry at zero.
// Latency: expire is decoded from the count register, so it follows clr/en by one cycle.
// Backpressure: none; saturates at zero until reloaded.
module ba_tmo_cnt #(
  parameter int TMO_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TMO_CYCLES);
  // The last WAIT cycle is the (TMO_CYCLES-1)th, so load TMO_CYCLES-2 and fire at zero.
  localparam logic [CW-1:0] LOAD = CW'(TMO_CYCLES - 2);

  logic [CW-1:0] cnt;

  // Reload on acceptance, then count down once per WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/ba_resp_4x4.sv
// Grant responder: latches the arbiter winner, issues one request to the target, returns ack/done.
// Latency: ack/done 3 cycles after grant at minimum; next grant sampled 5 cycles after the previous one.
// Backpressure: holds request while tgt_ready=0; a silent target is aborted after TMO_CYCLES in WAIT.
module ba_resp_4x4
  import ba_pkg::*;
#(
  parameter int DW         = 32,
  parameter int TMO_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    grant,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               ack,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      resp_data,
  output logic               err,
  output logic               tgt_valid,
  input  logic               tgt_ready,
  output logic [1:0]         tgt_id,
  output logic [DW-1:0]      tgt_data,
  input  logic               tgt_resp_valid,
  input  logic [DW-1:0]      tgt_resp_data,
  output logic               grant_err
);

  ba_resp_state_e state;
  ba_id_t         id_q;
  logic [DW-1:0]  data_q;
  logic [DW-1:0]  resp_q;
  logic           err_q;
  logic           grant_err_q;
  logic           tmo_clr;
  logic           tmo_en;
  logic           tmo_expire;
  ba_id_t         gid;

  assign gid     = ba_onehot_lsb(grant);
  assign tmo_clr = (state == ISSUE) && tgt_ready;
  assign tmo_en  = (state == WAIT);

  ba_tmo_cnt #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // Transaction sequencer: capture winner, issue, await response or timeout, ack, then a guard cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      id_q        <= '0;
      data_q      <= '0;
      resp_q      <= '0;
      err_q       <= 1'b0;
      grant_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != '0) begin
            id_q   <= gid;
            data_q <= req_data[int'(gid)*DW +: DW];
            state  <= ISSUE;
            if (ba_is_multihot(grant)) grant_err_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (tgt_ready) state <= WAIT;
        end
        WAIT: begin
          // A response arriving on the expiry cycle still counts as a normal completion.
          if (tgt_resp_valid) begin
            resp_q <= tgt_resp_data;
            err_q  <= 1'b0;
            state  <= ACK;
          end else if (tmo_expire) begin
            resp_q <= '0;
            err_q  <= 1'b1;
            state  <= ACK;
          end
        end
        ACK: begin
          state <= GAP;
        end
        GAP: begin
          // Response qualifiers are only meaningful alongside done; drop them here.
          resp_q <= '0;
          err_q  <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ack       = (state == ACK);
  assign done      = ack ? (4'b0001 << id_q) : 4'b0000;
  assign resp_data = resp_q;
  assign err       = err_q;
  assign tgt_valid = (state == ISSUE);
  assign tgt_id    = id_q;
  assign tgt_data  = data_q;
  assign grant_err = grant_err_q;

endmodule

// File: tb/tb_ba_resp_4x4.sv
// Directed bench for ba_resp_4x4 with a behavioural round-robin arbiter in front of it.
// Latency: inputs driven and outputs sampled on the falling edge, one clock cycle per step.
// Backpressure: tgt_ready and tgt_resp_valid are scripted per test.
module tb_ba_resp_4x4;
  import ba_pkg::*;

  localparam int DW  = 32;
  localparam int TMO = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      grant;
  logic [3:0]      grant_drv;
  logic [3:0]      arb_grant;
  logic [3:0]      arb_req;
  logic            arb_en;
  logic [1:0]      token;
  logic [4*DW-1:0] req_data;
  logic            ack;
  logic [3:0]      done;
  logic [DW-1:0]   resp_data;
  logic            err;
  logic            tgt_valid;
  logic            tgt_ready;
  logic [1:0]      tgt_id;
  logic [DW-1:0]   tgt_data;
  logic            tgt_resp_valid;
  logic [DW-1:0]   tgt_resp_data;
  logic            grant_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign grant = arb_en ? arb_grant : grant_drv;

  // Round-robin arbiter: first requester at or after the token wins.
  always_comb begin
    arb_grant = '0;
    for (int k = 3; k >= 0; k--) begin
      if (arb_req[(int'(token) + k) % 4]) arb_grant = 4'b0001 << ((int'(token) + k) % 4);
    end
  end

  // Token moves past the winner on every ack while the arbiter drives grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) token <= 2'd0;
    else if (ack && arb_en) token <= ba_onehot_lsb(done) + 2'd1;
  end

  ba_resp_4x4 #(
    .DW         (DW),
    .TMO_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .grant          (grant),
    .req_data       (req_data),
    .ack            (ack),
    .done           (done),
    .resp_data      (resp_data),
    .err            (err),
    .tgt_valid      (tgt_valid),
    .tgt_ready      (tgt_ready),
    .tgt_id         (tgt_id),
    .tgt_data       (tgt_data),
    .tgt_resp_valid (tgt_resp_valid),
    .tgt_resp_data  (tgt_resp_data),
    .grant_err      (grant_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".ack"},       64'(ack),       64'd0);
    check_eq({tag, ".done"},      64'(done),      64'd0);
    check_eq({tag, ".err"},       64'(err),       64'd0);
    check_eq({tag, ".resp_data"}, 64'(resp_data), 64'd0);
    check_eq({tag, ".tgt_valid"}, 64'(tgt_valid), 64'd0);
    check_eq({tag, ".tgt_id"},    64'(tgt_id),    64'd0);
    check_eq({tag, ".tgt_data"},  64'(tgt_data),  64'd0);
    check_eq({tag, ".grant_err"}, 64'(grant_err), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_ack;
    logic prev_ack;
    logic [3:0] exp_seq [6];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    rst_n          = 1'b0;
    grant_drv      = '0;
    arb_en         = 1'b0;
    arb_req        = '0;
    req_data       = '0;
    tgt_ready      = 1'b1;
    tgt_resp_valid = 1'b0;
    tgt_resp_data  = '0;
    cyc(2);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Minimum-latency transaction for requester 2.
    req_data[2*DW +: DW] = 32'hA5A5_0002;
    cyc(1); grant_drv = 4'b0100;                                // c0
    cyc(1); grant_drv = 4'b0000;                                // c1
    check_eq("t1.tgt_valid", 64'(tgt_valid), 64'd1);
    check_eq("t1.tgt_id",    64'(tgt_id),    64'd2);
    check_eq("t1.tgt_data",  64'(tgt_data),  64'hA5A5_0002);
    cyc(1); tgt_resp_valid = 1'b1; tgt_resp_data = 32'h1234;   // c2
    check_eq("t1.ack_c2", 64'(ack), 64'd0);
    cyc(1); tgt_resp_valid = 1'b0;                              // c3
    check_eq("t1.ack",       64'(ack),       64'd1);
    check_eq("t1.done",      64'(done),      64'b0100);
    check_eq("t1.resp_data", 64'(resp_data), 64'h1234);
    check_eq("t1.err",       64'(err),       64'd0);
    cyc(1);                                                     // c4: GAP, grant must be ignored
    check_eq("t1.gap_ack", 64'(ack), 64'd0);
    req_data[0 +: DW] = 32'h0000_0B0B;
    grant_drv = 4'b0001;

    // Next grant sampled in c5 only; target then stalls for 5 cycles.
    cyc(1); tgt_ready = 1'b0;                                   // c5
    check_eq("t2.gap_ignored", 64'(tgt_valid), 64'd0);
    cyc(1); grant_drv = 4'b0000;                                // c6
    for (int i = 0; i < 5; i++) begin                           // c6..c10
      check_eq("t2.hold_valid", 64'(tgt_valid), 64'd1);
      check_eq("t2.hold_id",    64'(tgt_id),    64'd0);
      check_eq("t2.hold_data",  64'(tgt_data),  64'h0000_0B0B);
      check_eq("t2.hold_ack",   64'(ack),       64'd0);
      cyc(1);
    end
    tgt_ready = 1'b1;                                           // c11
    check_eq("t2.valid_c11", 64'(tgt_valid), 64'd1);
    cyc(1); tgt_resp_valid = 1'b1; tgt_resp_data = 32'h5678;   // c12
    check_eq("t2.ack_c12", 64'(ack), 64'd0);
    cyc(1); tgt_resp_valid = 1'b0;                              // c13
    check_eq("t2.ack",       64'(ack),       64'd1);
    check_eq("t2.done",      64'(done),      64'b0001);
    check_eq("t2.resp_data", 64'(resp_data), 64'h5678);
    cyc(2);                                                     // IDLE

    // Timeout: accepted at end of c1, ACK in c1+TMO = c5.
    grant_drv = 4'b0010;                                        // c0
    cyc(1); grant_drv = 4'b0000;                                // c1
    check_eq("t3.tgt_id", 64'(tgt_id), 64'd1);
    for (int i = 2; i <= 4; i++) begin
      cyc(1);
      check_eq("t3.wait_ack", 64'(ack), 64'd0);
    end
    cyc(1);                                                     // c5
    check_eq("t3.ack",       64'(ack),       64'd1);
    check_eq("t3.done",      64'(done),      64'b0010);
    check_eq("t3.err",       64'(err),       64'd1);
    check_eq("t3.resp_data", 64'(resp_data), 64'd0);
    cyc(1); tgt_resp_valid = 1'b1; tgt_resp_data = 32'hDEAD;   // c6 GAP: late response
    check_eq("t3.gap_ack", 64'(ack), 64'd0);
    cyc(1); tgt_resp_valid = 1'b0;                              // c7
    check_eq("t3.late_ack",  64'(ack),  64'd0);
    cyc(1);                                                     // c8
    check_eq("t3.late_done", 64'(done), 64'd0);

    // Response on the expiry cycle wins over the timeout.
    grant_drv = 4'b1000;                                        // c0
    cyc(1); grant_drv = 4'b0000;                                // c1
    cyc(3); tgt_resp_valid = 1'b1; tgt_resp_data = 32'h9ABC;   // c4: last WAIT cycle
    cyc(1); tgt_resp_valid = 1'b0;                              // c5
    check_eq("t4.ack",       64'(ack),       64'd1);
    check_eq("t4.done",      64'(done),      64'b1000);
    check_eq("t4.err",       64'(err),       64'd0);
    check_eq("t4.resp_data", 64'(resp_data), 64'h9ABC);
    cyc(2);

    // Multi-hot grant: lowest index wins, sticky error flag.
    req_data[1*DW +: DW] = 32'h1111_0001;
    check_eq("t5.gerr_before", 64'(grant_err), 64'd0);
    grant_drv = 4'b1010;                                        // c0
    cyc(1); grant_drv = 4'b0000;                                // c1
    check_eq("t5.tgt_id",    64'(tgt_id),    64'd1);
    check_eq("t5.tgt_data",  64'(tgt_data),  64'h1111_0001);
    check_eq("t5.grant_err", 64'(grant_err), 64'd1);
    cyc(1); tgt_resp_valid = 1'b1; tgt_resp_data = 32'h0042;   // c2
    cyc(1); tgt_resp_valid = 1'b0;                              // c3
    check_eq("t5.done", 64'(done), 64'b0010);
    cyc(2);                                                     // c5
    check_eq("t5.gerr_sticky", 64'(grant_err), 64'd1);

    // Reset during WAIT, then a normal transaction.
    grant_drv = 4'b0100;                                        // c0
    cyc(1); grant_drv = 4'b0000;                                // c1
    check_eq("t6.tgt_id_pre", 64'(tgt_id), 64'd2);
    cyc(1);                                                     // c2: WAIT
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6.async");
    cyc(2);
    check_eq("t6.rst_ack", 64'(ack), 64'd0);
    rst_n = 1'b1;
    req_data[0 +: DW] = 32'h0000_C0DE;
    cyc(1); grant_drv = 4'b0001;                                // c0
    cyc(1); grant_drv = 4'b0000;                                // c1
    check_eq("t6.tgt_data", 64'(tgt_data), 64'h0000_C0DE);
    cyc(1); tgt_resp_valid = 1'b1; tgt_resp_data = 32'h4242;   // c2
    cyc(1); tgt_resp_valid = 1'b0;                              // c3
    check_eq("t6.ack",       64'(ack),       64'd1);
    check_eq("t6.done",      64'(done),      64'b0001);
    check_eq("t6.resp_data", 64'(resp_data), 64'h4242);
    cyc(2);

    // All four requesting through the arbiter: done rotates 0,1,2,3,0,1.
    tgt_ready      = 1'b1;
    tgt_resp_valid = 1'b1;
    tgt_resp_data  = 32'h77;
    arb_req        = 4'b1111;
    arb_en         = 1'b1;                                      // c0
    n_ack    = 0;
    prev_ack = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (ack) begin
        check_eq("rr.ack_gap", 64'(prev_ack), 64'd0);
        if (n_ack < 6) check_eq("rr.done", 64'(done), 64'(exp_seq[n_ack]));
        check_eq("rr.err", 64'(err), 64'd0);
        n_ack++;
      end
      prev_ack = ack;
    end
    check_eq("rr.n_ack", 64'(n_ack), 64'd6);
    arb_en         = 1'b0;
    arb_req        = '0;
    tgt_resp_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
